// File: rtl/card_dealer.sv
// BlackJack card dealer: picks undealt cards from a 52-card bitmap using the free-running count.
// Define CARD_DEALER_FIXED_SEQ_EN to deal in index order 0..51 instead (i_Count ignored).
module card_dealer #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned MAX_CARDS = 52
) (
  input  logic             clk_50M,
  input  logic             i_Reset,
  input  logic [WIDTH-1:0] i_Count,
  input  logic             i_Deal,
  input  logic             i_Shuffle,
  output logic [3:0]       o_Rank,
  output logic [1:0]       o_Suit,
  output logic [3:0]       o_Value,
  output logic             o_Valid,
  output logic             o_Busy,
  output logic             o_Empty,
  output logic [5:0]       o_Dealt
);

  localparam logic [5:0] DeckSize = 6'(MAX_CARDS);
  localparam logic [5:0] LastIdx  = 6'(MAX_CARDS - 1);

  typedef enum logic [1:0] {StIdle, StProbe, StDone} state_e;

  state_e               state_q;
  logic [5:0]           idx_q;
  logic [MAX_CARDS-1:0] used_q;

  logic [5:0] raw_idx;
  logic [5:0] start_idx;
  logic [3:0] card_rank;
  logic [1:0] card_suit;
  logic [3:0] card_value;
  logic       unused_count;

  assign unused_count = ^{1'b0, i_Count};

`ifdef CARD_DEALER_FIXED_SEQ_EN
  assign raw_idx = o_Dealt;
`else
  assign raw_idx = i_Count[5:0];
`endif

  // Fold 52..63 back onto 0..11.
  assign start_idx = (raw_idx >= DeckSize) ? raw_idx - DeckSize : raw_idx;

  always_comb begin
    card_suit = 2'd0;
    card_rank = 4'd0;
    if (idx_q >= 6'd39) begin
      card_suit = 2'd3;
      card_rank = 4'(idx_q - 6'd38);
    end else if (idx_q >= 6'd26) begin
      card_suit = 2'd2;
      card_rank = 4'(idx_q - 6'd25);
    end else if (idx_q >= 6'd13) begin
      card_suit = 2'd1;
      card_rank = 4'(idx_q - 6'd12);
    end else begin
      card_suit = 2'd0;
      card_rank = 4'(idx_q + 6'd1);
    end
    card_value = (card_rank > 4'd10) ? 4'd10 : card_rank;
  end

  always_ff @(posedge clk_50M or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      used_q  <= '0;
      o_Rank  <= '0;
      o_Suit  <= '0;
      o_Value <= '0;
      o_Valid <= 1'b0;
      o_Busy  <= 1'b0;
      o_Empty <= 1'b0;
      o_Dealt <= '0;
    end else if (i_Shuffle) begin
      // Card outputs deliberately keep their last value across a shuffle.
      state_q <= StIdle;
      used_q  <= '0;
      o_Valid <= 1'b0;
      o_Busy  <= 1'b0;
      o_Empty <= 1'b0;
      o_Dealt <= '0;
    end else begin
      o_Valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_Deal && !o_Empty) begin
            idx_q   <= start_idx;
            o_Busy  <= 1'b1;
            state_q <= StProbe;
          end
        end
        StProbe: begin
          if (!used_q[idx_q]) begin
            used_q[idx_q] <= 1'b1;
            o_Dealt       <= o_Dealt + 6'd1;
            o_Empty       <= (o_Dealt + 6'd1 == DeckSize);
            o_Rank        <= card_rank;
            o_Suit        <= card_suit;
            o_Value       <= card_value;
            o_Valid       <= 1'b1;
            o_Busy        <= 1'b0;
            state_q       <= StDone;
          end else begin
            idx_q <= (idx_q == LastIdx) ? 6'd0 : idx_q + 6'd1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Directed self-checking bench for card_dealer (default build, count-seeded start index).
module tb_card_dealer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] count = '0;
  logic        deal = 1'b0;
  logic        shuffle = 1'b0;
  logic [3:0]  rank;
  logic [1:0]  suit;
  logic [3:0]  value;
  logic        valid;
  logic        busy;
  logic        empty;
  logic [5:0]  dealt;

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  card_dealer #(.WIDTH(12), .MAX_CARDS(52)) dut (
    .clk_50M  (clk),
    .i_Reset  (rst_n),
    .i_Count  (count),
    .i_Deal   (deal),
    .i_Shuffle(shuffle),
    .o_Rank   (rank),
    .o_Suit   (suit),
    .o_Value  (value),
    .o_Valid  (valid),
    .o_Busy   (busy),
    .o_Empty  (empty),
    .o_Dealt  (dealt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request one deal and wait (bounded) for the valid pulse; lat counts edges after the sampling edge.
  task automatic do_deal(input logic [11:0] cnt, output logic got, output logic [3:0] r,
                         output logic [1:0] s, output logic [3:0] v, output int lat,
                         output logic valid_after);
    count = cnt;
    deal  = 1'b1;
    tick();
    deal = 1'b0;
    lat  = 0;
    while (!valid && lat < 60) begin
      tick();
      lat++;
    end
    got = valid;
    r   = rank;
    s   = suit;
    v   = value;
    tick();
    valid_after = valid;
  endtask

  task automatic test_reset();
    logic seen_valid;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({rank, suit, value, valid, busy, empty, dealt} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {rank, suit, value, valid, busy, empty, dealt});
    end
    // Reset in the middle of a deal.
    count = 12'd0;
    deal  = 1'b1;
    tick();
    deal = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_busy got=%b want=1", busy);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, busy, dealt} !== 8'd0) begin
      failures++;
      $display("FAIL reset_async got=%h want=0", {valid, busy, dealt});
    end
    tick();
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (4) begin
      tick();
      seen_valid |= valid;
    end
    checks++;
    if ({seen_valid, busy, empty, dealt} !== 9'd0) begin
      failures++;
      $display("FAIL reset_after_release got=%h want=0", {seen_valid, busy, empty, dealt});
    end
  endtask

  task automatic test_basic_deals();
    logic got, va;
    logic [3:0] r, v;
    logic [1:0] s;
    int lat;
    // count, exp rank, suit, value, latency, dealt-after
    logic [11:0] cnt_t[5]  = '{12'd0, 12'd0, 12'd63, 12'd51, 12'd51};
    logic [3:0]  rank_t[5] = '{4'd1, 4'd2, 4'd12, 4'd13, 4'd3};
    logic [1:0]  suit_t[5] = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
    logic [3:0]  val_t[5]  = '{4'd1, 4'd2, 4'd10, 4'd10, 4'd3};
    int          lat_t[5]  = '{1, 2, 1, 1, 4};
    for (int i = 0; i < 5; i++) begin
      do_deal(cnt_t[i], got, r, s, v, lat, va);
      checks++;
      if ({got, r, s, v} !== {1'b1, rank_t[i], suit_t[i], val_t[i]}) begin
        failures++;
        $display("FAIL basic_card%0d got v=%b r=%0d s=%0d val=%0d want r=%0d s=%0d val=%0d", i,
                 got, r, s, v, rank_t[i], suit_t[i], val_t[i]);
      end
      checks++;
      if (lat !== lat_t[i]) begin
        failures++;
        $display("FAIL basic_latency%0d got=%0d want=%0d", i, lat, lat_t[i]);
      end
      checks++;
      if (va !== 1'b0 || dealt !== 6'(i + 1)) begin
        failures++;
        $display("FAIL basic_pulse_dealt%0d got valid=%b dealt=%0d want valid=0 dealt=%0d", i, va,
                 dealt, i + 1);
      end
    end
    // Card outputs hold between deals.
    repeat (3) tick();
    checks++;
    if ({rank, suit, value} !== {4'd3, 2'd0, 4'd3}) begin
      failures++;
      $display("FAIL basic_hold got r=%0d s=%0d v=%0d want 3/0/3", rank, suit, value);
    end
  endtask

  task automatic test_full_deck();
    logic got, va, dup, seen_valid;
    logic [3:0] r, v, exp_v;
    logic [1:0] s;
    int lat, idx;
    logic [51:0] seen;
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    seen = '0;
    dup = 1'b0;
    for (int i = 0; i < 52; i++) begin
      do_deal(12'($urandom_range(0, 4095)), got, r, s, v, lat, va);
      idx   = int'(r) - 1 + 13 * int'(s);
      exp_v = (r > 4'd10) ? 4'd10 : r;
      checks++;
      if (!got || r < 4'd1 || r > 4'd13 || v !== exp_v || seen[idx]) begin
        failures++;
        $display("FAIL full_deal%0d got v=%b r=%0d s=%0d val=%0d", i, got, r, s, v);
        dup = 1'b1;
      end else begin
        seen[idx] = 1'b1;
      end
      if (i == 50) begin
        checks++;
        if (empty !== 1'b0) begin
          failures++;
          $display("FAIL full_not_empty51 got=%b want=0", empty);
        end
      end
    end
    checks++;
    if (seen !== {52{1'b1}} || empty !== 1'b1 || dealt !== 6'd52) begin
      failures++;
      $display("FAIL full_deck_end got seen=%h empty=%b dealt=%0d want all/1/52", seen, empty,
               dealt);
    end
    // A 53rd request on an empty deck must be ignored.
    count = 12'd7;
    deal  = 1'b1;
    tick();
    deal = 1'b0;
    seen_valid = valid;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL empty_busy got=%b want=0", busy);
    end
    repeat (5) begin
      tick();
      seen_valid |= valid | busy;
    end
    checks++;
    if (seen_valid !== 1'b0 || dealt !== 6'd52) begin
      failures++;
      $display("FAIL empty_no_deal got valid_or_busy=%b dealt=%0d want 0/52", seen_valid, dealt);
    end
  endtask

  task automatic test_shuffle();
    logic got, va, seen_valid;
    logic [3:0] r, v;
    logic [1:0] s;
    int lat;
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    do_deal(12'd0, got, r, s, v, lat, va);
    // idx 0 is now used, so this deal lingers in the probe state.
    count = 12'd0;
    deal  = 1'b1;
    tick();
    deal = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL shuffle_pre_busy got=%b want=1", busy);
    end
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    seen_valid = valid;
    repeat (4) begin
      tick();
      seen_valid |= valid;
    end
    checks++;
    if ({seen_valid, busy, empty, dealt} !== 9'd0) begin
      failures++;
      $display("FAIL shuffle_abort got=%h want=0", {seen_valid, busy, empty, dealt});
    end
    checks++;
    if ({rank, suit, value} !== {4'd1, 2'd0, 4'd1}) begin
      failures++;
      $display("FAIL shuffle_keeps_card got r=%0d s=%0d v=%0d want 1/0/1", rank, suit, value);
    end
    do_deal(12'd5, got, r, s, v, lat, va);
    checks++;
    if ({got, r, s, v, dealt} !== {1'b1, 4'd6, 2'd0, 4'd6, 6'd1} || lat != 1) begin
      failures++;
      $display("FAIL shuffle_next_deal got v=%b r=%0d s=%0d val=%0d dealt=%0d lat=%0d", got, r,
               s, v, dealt, lat);
    end
    // Shuffle and deal in the same cycle: shuffle wins.
    count   = 12'd7;
    deal    = 1'b1;
    shuffle = 1'b1;
    tick();
    deal    = 1'b0;
    shuffle = 1'b0;
    seen_valid = valid | busy;
    repeat (4) begin
      tick();
      seen_valid |= valid | busy;
    end
    checks++;
    if (seen_valid !== 1'b0 || dealt !== 6'd0) begin
      failures++;
      $display("FAIL shuffle_deal_same got activity=%b dealt=%0d want 0/0", seen_valid, dealt);
    end
  endtask

  task automatic test_shuffle_in_done();
    int waited;
    count = 12'd20;
    deal  = 1'b1;
    tick();
    deal = 1'b0;
    waited = 0;
    while (!valid && waited < 60) begin
      tick();
      waited++;
    end
    checks++;
    if (valid !== 1'b1 || dealt !== 6'd1) begin
      failures++;
      $display("FAIL done_pulse got valid=%b dealt=%0d want 1/1", valid, dealt);
    end
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    checks++;
    if ({valid, dealt} !== 7'd0 || {rank, suit} !== {4'd8, 2'd1}) begin
      failures++;
      $display("FAIL done_shuffle got valid=%b dealt=%0d r=%0d s=%0d want 0/0/8/1", valid, dealt,
               rank, suit);
    end
  endtask

  initial begin
    test_reset();
    test_basic_deals();
    test_full_deck();
    test_shuffle();
    test_shuffle_in_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
